// File: rtl/fetch_queue_unit_if.sv
// Handshake bundle between the fetch queue unit, the instruction memory and decode.
// The master side is the fetch unit itself; the slave side is the environment
// (memory on the request/response channels, decode on the instruction channel).
interface fetch_queue_unit_if;

   // Instruction memory request channel
   logic        req_valid_o;
   logic        req_ready_i;
   logic [31:0] req_addr_o;

   // Instruction memory response channel (in request order)
   logic        rsp_valid_i;
   logic        rsp_ready_o;
   logic [31:0] rsp_addr_i;
   logic [31:0] rsp_instr_i;

   // Decode-facing instruction queue head
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic [31:0] instr_pc_o;
   logic [31:0] instr_o;

   modport master (
      output req_valid_o,
      output req_addr_o,
      input  req_ready_i,
      input  rsp_valid_i,
      output rsp_ready_o,
      input  rsp_addr_i,
      input  rsp_instr_i,
      output instr_valid_o,
      input  instr_ready_i,
      output instr_pc_o,
      output instr_o
   );

   modport slave (
      input  req_valid_o,
      input  req_addr_o,
      output req_ready_i,
      output rsp_valid_i,
      input  rsp_ready_o,
      output rsp_addr_i,
      output rsp_instr_i,
      input  instr_valid_o,
      output instr_ready_i,
      input  instr_pc_o,
      input  instr_o
   );

endinterface

// File: rtl/fetch_queue_unit.sv
// Fetch stage: PC generator, in-order instruction memory port with a bounded
// number of requests in flight, and a small instruction queue feeding decode.
// Queue space is reserved at request time (count + live responses), so a
// returning response can always be accepted. After a redirect every response
// still in flight is stale and is counted off through drop_q.
module fetch_queue_unit #(
   parameter logic [31:0] RESET_PC        = 32'h8000_0000,
   parameter int          FQ_DEPTH        = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 redirect_i,
   input  logic [31:0]          redirect_pc_i,
   fetch_queue_unit_if.master   fq
);

   localparam int CNT_W = $clog2(FQ_DEPTH + 1);
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int PTR_W = $clog2(FQ_DEPTH);
   localparam int OCC_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [OUT_W-1:0] OUT_ONE   = OUT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [OUT_W-1:0] OUT_LIMIT = OUT_W'(MAX_OUTSTANDING);
   localparam logic [OCC_W-1:0] OCC_LIMIT = OCC_W'(FQ_DEPTH);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(FQ_DEPTH);

   // Architectural state
   logic [31:0]      pc_q;
   logic [CNT_W-1:0] count_q;
   logic [OUT_W-1:0] inflight_q;
   logic [OUT_W-1:0] drop_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] wr_ptr_q;

   // Queue storage, one PC and one instruction word per entry
   logic [31:0] pc_mem    [FQ_DEPTH];
   logic [31:0] instr_mem [FQ_DEPTH];

   // Derived control
   logic [OUT_W-1:0] live;
   logic [OCC_W-1:0] occupancy;
   logic             room_inflight;
   logic             room_queue;
   logic             req_valid;
   logic             req_fire;
   logic             rsp_fire;
   logic             drop_rsp;
   logic             push;
   logic             instr_valid;
   logic             pop;
   logic [OUT_W-1:0] inflight_after_rsp;

   // Low address bits of the redirect target are forced to zero
   logic unused_redirect_bits;
   assign unused_redirect_bits = ^redirect_pc_i[1:0];

   // Request/response/queue handshake decisions for the current cycle
   always_comb begin
      live               = inflight_q - drop_q;
      occupancy          = OCC_W'(count_q) + OCC_W'(live);
      room_inflight      = inflight_q < OUT_LIMIT;
      room_queue         = occupancy < OCC_LIMIT;
      req_valid          = !rst_i && !redirect_i && room_inflight && room_queue;
      req_fire           = req_valid && fq.req_ready_i;
      rsp_fire           = fq.rsp_valid_i;
      drop_rsp           = rsp_fire && (drop_q != '0);
      push               = rsp_fire && (drop_q == '0) && !redirect_i && !rst_i;
      instr_valid        = count_q != '0;
      pop                = instr_valid && fq.instr_ready_i && !redirect_i && !rst_i;
      inflight_after_rsp = rsp_fire ? (inflight_q - OUT_ONE) : inflight_q;
   end

   assign fq.req_valid_o   = req_valid;
   assign fq.req_addr_o    = pc_q;
   assign fq.rsp_ready_o   = 1'b1;
   assign fq.instr_valid_o = instr_valid;
   assign fq.instr_pc_o    = pc_mem[rd_ptr_q];
   assign fq.instr_o       = instr_mem[rd_ptr_q];

   // PC, in-flight/drop accounting and queue pointers; reset beats redirect beats normal flow
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q       <= RESET_PC;
         count_q    <= '0;
         inflight_q <= '0;
         drop_q     <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else if (redirect_i) begin
         pc_q       <= {redirect_pc_i[31:2], 2'b00};
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         inflight_q <= inflight_after_rsp;
         drop_q     <= inflight_after_rsp;
      end else begin
         if (req_fire) begin
            pc_q <= pc_q + 32'd4;
         end

         case ({req_fire, rsp_fire})
            2'b10:   inflight_q <= inflight_q + OUT_ONE;
            2'b01:   inflight_q <= inflight_q - OUT_ONE;
            default: inflight_q <= inflight_q;
         endcase

         if (drop_rsp) begin
            drop_q <= drop_q - OUT_ONE;
         end

         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end

         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end

         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   // Queue entry write on accepted, non-stale response
   always_ff @(posedge clk_i) begin
      if (push) begin
         pc_mem[wr_ptr_q]    <= fq.rsp_addr_i;
         instr_mem[wr_ptr_q] <= fq.rsp_instr_i;
      end
   end

   // Reservation must keep every push in range, and responses only come back for issued requests
   always_ff @(posedge clk_i) begin
      if (!rst_i && push) begin
         assert (count_q < CNT_LIMIT);
      end
      if (!rst_i && rsp_fire) begin
         assert (inflight_q != '0);
      end
   end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: an in-order memory model with
// configurable latency and a scoreboard that tags every request with the
// fetch epoch in which it was issued (a redirect or reset starts a new epoch;
// responses from older epochs must never reach decode).
module tb_fetch_queue_unit;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam int          FQ_DEPTH = 4;
   localparam int          MAX_OUT  = 2;

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          issue;
   } pend_t;

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;

   fetch_queue_unit_if fq_bus();

   fetch_queue_unit #(
      .RESET_PC        (RESET_PC),
      .FQ_DEPTH        (FQ_DEPTH),
      .MAX_OUTSTANDING (MAX_OUT)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .fq            (fq_bus)
   );

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          mem_lat = 1;
   int          mem_stall_pct = 0;
   int          epoch = 0;
   int          act_inflight = 0;
   logic [31:0] model_pc = RESET_PC;
   pend_t       pend[$];
   logic [63:0] sq[$];

   logic        obs_req_valid;
   logic [31:0] obs_req_addr;
   logic        obs_instr_valid;
   logic [31:0] obs_instr_pc;
   logic        obs_pop;
   logic        obs_req_fire;
   int          obs_cyc;

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always ends
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
   endfunction

   function automatic bit rsp_due();
      if (pend.size() == 0) return 1'b0;
      return cyc >= pend[0].issue + mem_lat;
   endfunction

   // One clock cycle: drive inputs, check DUT against the model, advance the model
   task automatic cycle(input bit do_rst, input bit do_redir, input logic [31:0] rpc,
                        input bit req_rdy, input bit dec_rdy);
      bit          exp_rv;
      bit          rsp_v;
      int          live;
      pend_t       e;
      logic [63:0] hd;
      @(negedge clk);
      rst                  = do_rst;
      redirect             = do_redir;
      redirect_pc          = rpc;
      fq_bus.req_ready_i   = req_rdy;
      fq_bus.instr_ready_i = dec_rdy;
      rsp_v = 1'b0;
      if (rsp_due()) rsp_v = ($urandom_range(99) >= mem_stall_pct);
      fq_bus.rsp_valid_i = rsp_v;
      if (rsp_v) begin
         fq_bus.rsp_addr_i  = pend[0].addr;
         fq_bus.rsp_instr_i = instr_of(pend[0].addr);
      end else begin
         fq_bus.rsp_addr_i  = 32'h0;
         fq_bus.rsp_instr_i = 32'h0;
      end
      #1;
      live = 0;
      foreach (pend[k]) if (pend[k].epoch == epoch) live++;
      exp_rv = !do_rst && !do_redir && (pend.size() < MAX_OUT) && ((sq.size() + live) < FQ_DEPTH);

      obs_cyc         = cyc;
      obs_req_valid   = fq_bus.req_valid_o;
      obs_req_addr    = fq_bus.req_addr_o;
      obs_instr_valid = fq_bus.instr_valid_o;
      obs_instr_pc    = fq_bus.instr_pc_o;
      obs_pop         = (obs_instr_valid === 1'b1) && dec_rdy && !do_rst && !do_redir;
      obs_req_fire    = (obs_req_valid === 1'b1) && req_rdy;

      total++;
      if (fq_bus.req_valid_o !== exp_rv) begin
         bad++;
         $display("[TB] FAIL req_valid @%0d: got %b required %b", cyc, fq_bus.req_valid_o, exp_rv);
      end
      if (exp_rv) begin
         total++;
         if (fq_bus.req_addr_o !== model_pc) begin
            bad++;
            $display("[TB] FAIL req_addr @%0d: got %h required %h", cyc, fq_bus.req_addr_o, model_pc);
         end
      end
      total++;
      if (fq_bus.rsp_ready_o !== 1'b1) begin
         bad++;
         $display("[TB] FAIL rsp_ready @%0d: got %b required 1", cyc, fq_bus.rsp_ready_o);
      end
      total++;
      if (fq_bus.instr_valid_o !== (sq.size() != 0)) begin
         bad++;
         $display("[TB] FAIL instr_valid @%0d: got %b required %b", cyc, fq_bus.instr_valid_o, sq.size() != 0);
      end
      if (sq.size() != 0) begin
         total++;
         if ({fq_bus.instr_pc_o, fq_bus.instr_o} !== sq[0]) begin
            bad++;
            $display("[TB] FAIL head @%0d: got %h required %h", cyc, {fq_bus.instr_pc_o, fq_bus.instr_o}, sq[0]);
         end
      end

      if (do_rst) act_inflight = 0;
      else act_inflight = act_inflight + (obs_req_fire ? 1 : 0) - (rsp_v ? 1 : 0);

      if (do_rst) begin
         pend.delete();
         sq.delete();
         epoch++;
         model_pc = RESET_PC;
      end else if (do_redir) begin
         sq.delete();
         epoch++;
         model_pc = rpc & 32'hFFFF_FFFC;
         if (rsp_v) e = pend.pop_front();
      end else begin
         if (sq.size() != 0 && dec_rdy) hd = sq.pop_front();
         if (rsp_v) begin
            e = pend.pop_front();
            if (e.epoch == epoch) sq.push_back({e.addr, instr_of(e.addr)});
         end
         if (exp_rv && req_rdy) begin
            pend.push_back('{addr: model_pc, epoch: epoch, issue: cyc});
            model_pc = model_pc + 32'd4;
         end
      end
      @(posedge clk);
      cyc++;
   endtask

   // Reset leaves an empty queue and a request pending at RESET_PC
   task automatic test_reset();
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      total++;
      if (obs_req_valid !== 1'b1 || obs_req_addr !== RESET_PC) begin
         bad++;
         $display("[TB] FAIL reset_req: got %b/%h required 1/%h", obs_req_valid, obs_req_addr, RESET_PC);
      end
      total++;
      if (obs_instr_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_instr_valid: got %b required 0", obs_instr_valid);
      end
   endtask

   // Sequential fetch at latency 1: in-order PCs, 2-cycle first-instruction latency
   task automatic test_sequential();
      int          first_fire = -1;
      int          first_valid = -1;
      logic [31:0] exp_next = RESET_PC;
      mem_lat = 1;
      mem_stall_pct = 0;
      cycle(1, 0, 0, 1, 1);
      for (int i = 0; i < 30; i++) begin
         cycle(0, 0, 0, 1, 1);
         if (first_fire < 0 && obs_req_fire) first_fire = obs_cyc;
         if (first_valid < 0 && obs_instr_valid === 1'b1) first_valid = obs_cyc;
         if (obs_pop) begin
            total++;
            if (obs_instr_pc !== exp_next) begin
               bad++;
               $display("[TB] FAIL seq_pc: got %h required %h", obs_instr_pc, exp_next);
            end
            exp_next = exp_next + 32'd4;
         end
      end
      total++;
      if (first_fire < 0 || first_valid - first_fire != 2) begin
         bad++;
         $display("[TB] FAIL first_latency: got %0d required 2", first_valid - first_fire);
      end
   endtask

   // Decode stalls: queue fills, requests stop, release drains without loss or duplication
   task automatic test_backpressure();
      logic [31:0] exp_next = RESET_PC;
      int          pops = 0;
      mem_lat = 1;
      cycle(1, 0, 0, 1, 0);
      for (int i = 0; i < 20; i++) cycle(0, 0, 0, $urandom_range(1), 0);
      total++;
      if (obs_req_valid !== 1'b0 || obs_instr_valid !== 1'b1) begin
         bad++;
         $display("[TB] FAIL full_queue: got req_valid=%b instr_valid=%b required 0/1", obs_req_valid, obs_instr_valid);
      end
      for (int i = 0; i < 30; i++) begin
         cycle(0, 0, 0, 1, 1);
         if (obs_pop) begin
            pops++;
            total++;
            if (obs_instr_pc !== exp_next) begin
               bad++;
               $display("[TB] FAIL drain_pc: got %h required %h", obs_instr_pc, exp_next);
            end
            exp_next = exp_next + 32'd4;
         end
      end
      total++;
      if (pops < FQ_DEPTH) begin
         bad++;
         $display("[TB] FAIL drain_count: got %0d required >=%0d", pops, FQ_DEPTH);
      end
   endtask

   // Latency 3 with random handshakes: never more than MAX_OUT in flight
   task automatic test_latency3();
      mem_lat = 3;
      cycle(1, 0, 0, 1, 1);
      for (int i = 0; i < 80; i++) begin
         cycle(0, 0, 0, $urandom_range(3) != 0, $urandom_range(2) != 0);
         total++;
         if (act_inflight > MAX_OUT) begin
            bad++;
            $display("[TB] FAIL max_inflight: got %0d required <=%0d", act_inflight, MAX_OUT);
         end
      end
   endtask

   // Redirect with two in flight, then redirect coinciding with a response
   task automatic test_redirect();
      bit          found;
      logic [31:0] got;
      mem_lat = 3;
      mem_stall_pct = 0;
      cycle(1, 0, 0, 1, 1);
      for (int i = 0; i < 10 && !(act_inflight == MAX_OUT && !rsp_due()); i++) cycle(0, 0, 0, 1, 1);
      cycle(0, 1, 32'h8000_0103, 1, 1);
      found = 0;
      for (int i = 0; i < 12 && !found; i++) begin
         cycle(0, 0, 0, 1, 1);
         if (obs_req_valid === 1'b1) begin found = 1; got = obs_req_addr; end
      end
      total++;
      if (!found || got !== 32'h8000_0100) begin
         bad++;
         $display("[TB] FAIL redirect_req: got %h required 80000100", got);
      end
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle(0, 0, 0, 1, 1);
         if (obs_pop) begin found = 1; got = obs_instr_pc; end
      end
      total++;
      if (!found || got !== 32'h8000_0100) begin
         bad++;
         $display("[TB] FAIL redirect_first_pc: got %h required 80000100", got);
      end
      for (int i = 0; i < 20 && !(act_inflight == MAX_OUT && rsp_due()); i++) cycle(0, 0, 0, 1, 1);
      cycle(0, 1, 32'h8000_0200, 1, 1);
      cycle(0, 0, 0, 1, 1);
      total++;
      if (obs_req_valid !== 1'b1 || obs_req_addr !== 32'h8000_0200) begin
         bad++;
         $display("[TB] FAIL redirect_rsp_req: got %b/%h required 1/80000200", obs_req_valid, obs_req_addr);
      end
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle(0, 0, 0, 1, 1);
         if (obs_pop) begin found = 1; got = obs_instr_pc; end
      end
      total++;
      if (!found || got !== 32'h8000_0200) begin
         bad++;
         $display("[TB] FAIL redirect_rsp_first_pc: got %h required 80000200", got);
      end
   endtask

   // Two back-to-back redirects then a mid-stream reset
   task automatic test_back_to_back();
      bit          found;
      logic [31:0] got;
      logic [31:0] exp_next;
      mem_lat = 2;
      cycle(1, 0, 0, 1, 1);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 1);
      cycle(0, 1, 32'h8000_1000, 1, 1);
      cycle(0, 1, 32'h8000_2002, 1, 1);
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         cycle(0, 0, 0, 1, 1);
         if (obs_pop) begin found = 1; got = obs_instr_pc; end
      end
      total++;
      if (!found || got !== 32'h8000_2000) begin
         bad++;
         $display("[TB] FAIL b2b_first_pc: got %h required 80002000", got);
      end
      exp_next = 32'h8000_2004;
      for (int i = 0; i < 15; i++) begin
         cycle(0, 0, 0, 1, $urandom_range(1));
         if (obs_pop) begin
            total++;
            if (obs_instr_pc !== exp_next) begin
               bad++;
               $display("[TB] FAIL b2b_pc: got %h required %h", obs_instr_pc, exp_next);
            end
            exp_next = exp_next + 32'd4;
         end
      end
      cycle(1, 0, 0, 1, 1);
      cycle(0, 0, 0, 1, 1);
      total++;
      if (obs_instr_valid !== 1'b0 || obs_req_valid !== 1'b1 || obs_req_addr !== RESET_PC) begin
         bad++;
         $display("[TB] FAIL midreset: got iv=%b rv=%b addr=%h required 0/1/%h",
                  obs_instr_valid, obs_req_valid, obs_req_addr, RESET_PC);
      end
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle(0, 0, 0, 1, 1);
         if (obs_pop) begin found = 1; got = obs_instr_pc; end
      end
      total++;
      if (!found || got !== RESET_PC) begin
         bad++;
         $display("[TB] FAIL midreset_first_pc: got %h required %h", got, RESET_PC);
      end
   endtask

   // Random mix of handshakes, memory stalls, latencies, redirects and resets
   task automatic test_random();
      mem_stall_pct = 25;
      cycle(1, 0, 0, 1, 1);
      for (int i = 0; i < 600; i++) begin
         if (i % 100 == 0) mem_lat = $urandom_range(4, 1);
         cycle($urandom_range(199) == 0, $urandom_range(99) < 4, $urandom,
               $urandom_range(3) != 0, $urandom_range(2) != 0);
      end
      mem_stall_pct = 0;
   endtask

   // Test sequence
   initial begin
      rst                  = 1'b1;
      redirect             = 1'b0;
      redirect_pc          = 32'h0;
      fq_bus.req_ready_i   = 1'b0;
      fq_bus.rsp_valid_i   = 1'b0;
      fq_bus.rsp_addr_i    = 32'h0;
      fq_bus.rsp_instr_i   = 32'h0;
      fq_bus.instr_ready_i = 1'b0;
      repeat (2) @(posedge clk);
      test_reset();
      test_sequential();
      test_backpressure();
      test_latency3();
      test_redirect();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
